// File: rtl/cache_write_buffer_pkg.sv
// cache_write_buffer_pkg: shared types for the posted-write buffer
package cache_write_buffer_pkg;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} wb_state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } wb_entry_t;
endpackage

// File: rtl/cache_write_buffer_if.sv
// cache_write_buffer_if: req/gnt/rvalid bus shared by the upstream and memory ports
interface cache_write_buffer_if;
    logic        req;
    logic        gnt;
    logic        we;
    logic        rvalid;
    logic        error;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    modport master (output req, addr, wdata, we, be, input gnt, rvalid, rdata, error);
    modport slave (input req, addr, wdata, we, be, output gnt, rvalid, rdata, error);
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: circular write-entry FIFO with registered occupancy count
module wb_fifo
    import cache_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    din,
    output wb_entry_t                    head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    wb_entry_t ram [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    assign head  = ram[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push) ram[wr_ptr] <= din;
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/cache_write_buffer.sv
// cache_write_buffer: posts cache writes into a FIFO, drains them in order, holds reads until empty
module cache_write_buffer
    import cache_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_write_buffer_if.slave  up,
    cache_write_buffer_if.master mem,
    output logic                 wr_error
);
    wb_state_t state, state_nxt;
    wb_entry_t head, push_entry;
    logic full, empty, rd_pending, wr_acc, rd_acc, pop, rd_done;
    logic [31:0] rd_addr;
    logic [$clog2(DEPTH+1)-1:0] count;
    assign push_entry = '{addr: up.addr, wdata: up.wdata, be: up.be};
    assign wr_acc  = up.req & up.we & ~full & ~rd_pending;
    assign rd_acc  = up.req & ~up.we & empty & (state == IDLE) & ~rd_pending;
    assign up.gnt  = wr_acc | rd_acc;
    assign pop     = (state == WR_WAIT) & mem.rvalid;
    assign rd_done = (state == RD_WAIT) & mem.rvalid;
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_acc),
        .pop   (pop),
        .din   (push_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    // A read accepted in IDLE goes straight to RD_REQ so memory sees it the next cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (count != '0) ? WR_REQ : (rd_pending | rd_acc) ? RD_REQ : IDLE;
            WR_REQ:  state_nxt = mem.gnt ? WR_WAIT : WR_REQ;
            WR_WAIT: state_nxt = mem.rvalid ? IDLE : WR_WAIT;
            RD_REQ:  state_nxt = mem.gnt ? RD_WAIT : RD_REQ;
            RD_WAIT: state_nxt = mem.rvalid ? IDLE : RD_WAIT;
            default: state_nxt = IDLE;
        endcase
        mem.req   = (state == WR_REQ) | (state == RD_REQ);
        mem.we    = state == WR_REQ;
        mem.addr  = (state == WR_REQ) ? head.addr : (state == RD_REQ) ? rd_addr : '0;
        mem.wdata = (state == WR_REQ) ? head.wdata : '0;
        mem.be    = (state == WR_REQ) ? head.be : (state == RD_REQ) ? 4'hf : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            rd_addr    <= '0;
            up.rvalid  <= 1'b0;
            up.rdata   <= '0;
            up.error   <= 1'b0;
            wr_error   <= 1'b0;
        end else begin
            up.rvalid <= wr_acc | rd_done;
            if (rd_acc) begin
                rd_pending <= 1'b1;
                rd_addr    <= up.addr;
            end else if (rd_done) begin
                rd_pending <= 1'b0;
            end
            if (wr_acc) begin
                up.rdata <= '0;
                up.error <= 1'b0;
            end else if (rd_done) begin
                up.rdata <= mem.rdata;
                up.error <= mem.error;
            end
            if (pop & mem.error) wr_error <= 1'b1;
        end
    end
endmodule
